is_uart_tx_buffer: RTL

//  Byte source for the UART controller DRP transmit port: buffers bytes written by the

---
 rtl/is_uart_tx_buffer_if.sv | 29 ++
 rtl/is_uart_tx_buffer.sv | 101 ++++++++++
 2 files changed

// File: rtl/is_uart_tx_buffer_if.sv
// Byte-write / DRP transmit bundle for is_uart_tx_buffer.
// slave is the buffer side; master is the user-logic plus controller side.
interface is_uart_tx_buffer_if #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          wr_en_i;
  logic [DW-1:0] wr_data_i;
  logic          flush_i;
  logic          full_o;
  logic          empty_o;
  logic [LW-1:0] level_o;
  logic          overflow_o;
  logic          tx_rdy_t_o;
  logic [DW-1:0] tx_data_r_o;
  logic          tx_rdy_r_i;

  modport slave (
    input  wr_en_i, wr_data_i, flush_i, tx_rdy_r_i,
    output full_o, empty_o, level_o, overflow_o, tx_rdy_t_o, tx_data_r_o
  );

  modport master (
    output wr_en_i, wr_data_i, flush_i, tx_rdy_r_i,
    input  full_o, empty_o, level_o, overflow_o, tx_rdy_t_o, tx_data_r_o
  );
endinterface

// File: rtl/is_uart_tx_buffer.sv
// UART DRP transmit buffer: DEPTH-1 entry circular store plus one output register
// that presents bytes on the tx_rdy_t/tx_rdy_r valid/ready handshake.
module is_uart_tx_buffer #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  is_uart_tx_buffer_if.slave     bus
);
  localparam int SD = DEPTH - 1;
  localparam int AW = (SD > 1) ? $clog2(SD) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  typedef enum logic {IDLE, OFFER} state_e;

  logic [DW-1:0] mem_q [SD];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] cnt_q, cnt_d, level;
  state_e        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic          ovf_q, ovf_d;
  logic          offer, accept, full, stor_empty, write_ok, load_slot, push, pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(SD - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    offer      = (state_q == OFFER);
    accept     = offer & bus.tx_rdy_r_i;
    level      = cnt_q + LW'(offer);
    full       = (level == LW'(DEPTH));
    stor_empty = (cnt_q == '0);
    write_ok   = bus.wr_en_i & ~full & ~bus.flush_i;
    load_slot  = ~offer | accept;

    state_d  = state_q;
    data_d   = data_q;
    ovf_d    = ovf_q | (bus.wr_en_i & full & ~bus.flush_i);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    pop      = 1'b0;

    if (bus.flush_i) begin
      // The offered byte survives a flush; only the stored backlog is dropped.
      cnt_d    = '0;
      rd_ptr_d = wr_ptr_q;
      if (accept) state_d = IDLE;
    end else begin
      if (load_slot) begin
        if (!stor_empty) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          state_d = OFFER;
        end else if (write_ok) begin
          data_d  = bus.wr_data_i;
          state_d = OFFER;
        end else begin
          state_d = IDLE;
        end
      end
      // A write bypasses storage only when it goes straight into the free output slot.
      push = write_ok & ~(stor_empty & load_slot);
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data_i;
  end

  assign bus.tx_rdy_t_o  = offer;
  assign bus.tx_data_r_o = data_q;
  assign bus.level_o     = level;
  assign bus.full_o      = full;
  assign bus.empty_o     = (level == '0);
  assign bus.overflow_o  = ovf_q;
endmodule
